// File: rtl/weight_shift_cell_pkg.sv
// Shared types and default geometry for the convolution-array weight cell.
// Scan states, the weight-update select, and the counter-width helper.
package weight_cell_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    typedef enum logic [2:0] {
        HOLD,
        XIN,
        YIN,
        HOME,
        MEM
    } upd_sel_t;

    localparam int DEF_NCH    = 16;
    localparam int DEF_WW     = 8;
    localparam int DEF_AW     = 4;
    localparam int DEF_K      = 3;
    localparam int DEF_OUTW   = 19;
    localparam int DEF_OUTH   = 19;
    localparam int DEF_RD_LAT = 1;

    // A counter of range 1 still needs one bit to exist.
    function automatic int cnt_w(input int n);
        return $clog2((n > 2) ? n : 2);
    endfunction

endpackage

// File: rtl/weight_shift_cell_if.sv
// Bus bundle between a weight cell and its memory, neighbours and sequencer.
// slave is the cell side; master is whatever drives the cell.
interface weight_shift_cell_if
    import weight_cell_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int WW   = DEF_WW,
    parameter int AW   = DEF_AW,
    parameter int K    = DEF_K,
    parameter int OUTW = DEF_OUTW,
    parameter int OUTH = DEF_OUTH
) ();
    logic                    start;
    logic [AW-1:0]           kidx;
    logic                    step;
    logic [NCH*AW-1:0]       mem_raddr;
    logic [NCH*WW-1:0]       mem_rdata;
    logic [NCH*WW-1:0]       w_xin;
    logic [NCH*WW-1:0]       w_yin;
    logic [NCH*WW-1:0]       w_q;
    logic                    ready;
    logic                    busy;
    logic                    finish;
    logic [cnt_w(K)-1:0]     cnt_x;
    logic [cnt_w(K)-1:0]     cnt_y;
    logic [cnt_w(OUTW)-1:0]  cnt_X;
    logic [cnt_w(OUTH)-1:0]  cnt_Y;

    modport slave (
        input  start, kidx, step, mem_rdata, w_xin, w_yin,
        output mem_raddr, w_q, ready, busy, finish, cnt_x, cnt_y, cnt_X, cnt_Y
    );

    modport master (
        output start, kidx, step, mem_rdata, w_xin, w_yin,
        input  mem_raddr, w_q, ready, busy, finish, cnt_x, cnt_y, cnt_X, cnt_Y
    );
endinterface

// File: rtl/weight_shift_cell_wrap_counter.sv
// Modulo-MAX counter; wrap flags the enabled cycle that returns it to zero,
// so chaining wrap -> en builds the nested scan.
module wrap_counter
    import weight_cell_pkg::*;
#(
    parameter int MAX = 3
) (
    input  logic                   clk,
    input  logic                   xrst,
    input  logic                   en,
    output logic [cnt_w(MAX)-1:0]  q,
    output logic                   wrap
);
    localparam int W = cnt_w(MAX);

    assign wrap = en && (q == W'(MAX - 1));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            q <= '0;
        end else if (en) begin
            q <= wrap ? '0 : q + 1'b1;
        end
    end
endmodule

// File: rtl/weight_shift_cell.sv
// One PE weight store: fetches NCH kernel weights from memory, then shifts
// them through the array as the x/X/y/Y scan advances.
module weight_shift_cell
    import weight_cell_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int WW     = DEF_WW,
    parameter int AW     = DEF_AW,
    parameter int K      = DEF_K,
    parameter int OUTW   = DEF_OUTW,
    parameter int OUTH   = DEF_OUTH,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              xrst,
    weight_shift_cell_if.slave bus
);
    localparam int LW = $clog2(RD_LAT + 1);

    state_t             r_state;
    logic [AW-1:0]      r_kidx;
    logic [LW-1:0]      r_lcnt;
    logic [NCH*WW-1:0]  r_w;
    logic [NCH*WW-1:0]  r_home;
    logic               r_ready;
    logic               r_busy;
    logic               r_finish;

    logic               w_step_acc;
    logic               w_start_acc;
    logic               w_load_done;
    logic               w_wrap_x;
    logic               w_wrap_X;
    logic               w_wrap_y;
    logic               w_wrap_Y;
    upd_sel_t           w_sel;
    logic [NCH*WW-1:0]  w_next;

    // r_busy stays high through the finish pulse so a start there is refused.
    assign w_start_acc = bus.start && (r_state == IDLE) && !r_busy;
    assign w_step_acc  = bus.step && (r_state == RUN);
    assign w_load_done = (r_state == LOAD) && (r_lcnt == LW'(RD_LAT));

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_raddr
            assign bus.mem_raddr[gi*AW +: AW] = r_kidx;
        end
    endgenerate

    wrap_counter #(.MAX(K))    u_cnt_x (.clk(clk), .xrst(xrst), .en(w_step_acc), .q(bus.cnt_x), .wrap(w_wrap_x));
    wrap_counter #(.MAX(OUTW)) u_cnt_X (.clk(clk), .xrst(xrst), .en(w_wrap_x),   .q(bus.cnt_X), .wrap(w_wrap_X));
    wrap_counter #(.MAX(K))    u_cnt_y (.clk(clk), .xrst(xrst), .en(w_wrap_X),   .q(bus.cnt_y), .wrap(w_wrap_y));
    wrap_counter #(.MAX(OUTH)) u_cnt_Y (.clk(clk), .xrst(xrst), .en(w_wrap_y),   .q(bus.cnt_Y), .wrap(w_wrap_Y));

    // Row change pulls from above; any other kernel-column wrap restores home.
    always_comb begin
        w_sel = HOLD;
        if (w_load_done) begin
            w_sel = MEM;
        end else if (w_step_acc) begin
            if (!w_wrap_x)
                w_sel = XIN;
            else if (w_wrap_X && !w_wrap_y)
                w_sel = YIN;
            else
                w_sel = HOME;
        end
    end

    always_comb begin
        w_next = r_w;
        case (w_sel)
            XIN:     w_next = bus.w_xin;
            YIN:     w_next = bus.w_yin;
            HOME:    w_next = r_home;
            MEM:     w_next = bus.mem_rdata;
            default: w_next = r_w;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state  <= IDLE;
            r_kidx   <= '0;
            r_lcnt   <= '0;
            r_w      <= '0;
            r_home   <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            if (r_finish)
                r_busy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
                        r_state <= LOAD;
                        r_kidx  <= bus.kidx;
                        r_lcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_load_done) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                RUN: begin
                    if (w_wrap_Y) begin
                        r_state  <= IDLE;
                        r_ready  <= 1'b0;
                        r_finish <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_sel != HOLD)
                r_w <= w_next;
            if (w_sel == MEM)
                r_home <= bus.mem_rdata;
        end
    end

    assign bus.w_q    = r_w;
    assign bus.ready  = r_ready;
    assign bus.busy   = r_busy;
    assign bus.finish = r_finish;
endmodule

// File: tb/tb_weight_shift_cell.sv
// Directed bench for weight_shift_cell: load timing at two read latencies,
// shift/restore selection, full scan, ignored controls and async reset.
module tb_weight_shift_cell;
    import weight_cell_pkg::*;

    localparam int NCH  = 16;
    localparam int WW   = 8;
    localparam int AW   = 4;
    localparam int K    = 3;
    localparam int OUTW = 19;
    localparam int OUTH = 19;

    localparam logic [127:0] LOADW = 128'h0706050403020100FFFEFDFCFBFAF9F8;
    localparam logic [127:0] XIN1  = {16{8'h11}};
    localparam logic [127:0] XIN2  = {16{8'h22}};
    localparam logic [127:0] YIN3  = 128'h333333333333333333333333F9333333;
    localparam logic [63:0]  RA5   = 64'h5555555555555555;

    logic clk;
    logic xrst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   nfin;
    int   fin_at;

    weight_shift_cell_if #(.NCH(NCH), .WW(WW), .AW(AW), .K(K), .OUTW(OUTW), .OUTH(OUTH)) b1 ();
    weight_shift_cell_if #(.NCH(NCH), .WW(WW), .AW(AW), .K(K), .OUTW(OUTW), .OUTH(OUTH)) b3 ();

    weight_shift_cell #(.NCH(NCH), .WW(WW), .AW(AW), .K(K), .OUTW(OUTW), .OUTH(OUTH), .RD_LAT(1))
        u_dut1 (.clk(clk), .xrst(xrst), .bus(b1.slave));
    weight_shift_cell #(.NCH(NCH), .WW(WW), .AW(AW), .K(K), .OUTW(OUTW), .OUTH(OUTH), .RD_LAT(3))
        u_dut3 (.clk(clk), .xrst(xrst), .bus(b3.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns c-8 on bank c at address 5, 0x55 elsewhere, after the pipeline delay.
    function automatic logic [NCH*WW-1:0] mem_fn(input logic [NCH*AW-1:0] ra);
        logic [NCH*WW-1:0] d;
        for (int c = 0; c < NCH; c++)
            d[c*WW +: WW] = (ra[c*AW +: AW] == 4'd5) ? 8'(c - 8) : 8'h55;
        return d;
    endfunction

    logic [NCH*WW-1:0] p1, p3a, p3b, p3c;
    always @(posedge clk) begin
        p1  <= mem_fn(b1.mem_raddr);
        p3a <= mem_fn(b3.mem_raddr);
        p3b <= p3a;
        p3c <= p3b;
    end
    assign b1.mem_rdata = p1;
    assign b3.mem_rdata = p3c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        xrst = 1'b1;
        b1.start = 1'b0; b1.kidx = '0; b1.step = 1'b0; b1.w_xin = '0; b1.w_yin = '0;
        b3.start = 1'b0; b3.kidx = '0; b3.step = 1'b0; b3.w_xin = '0; b3.w_yin = '0;
        #2 xrst = 1'b0;
        tick();
        tick();
        chk("rst_wq", b1.w_q, 128'h0);
        chk("rst_ready", b1.ready, 0);
        chk("rst_busy", b1.busy, 0);
        chk("rst_finish", b1.finish, 0);
        chk("rst_cnts", {b1.cnt_Y, b1.cnt_y, b1.cnt_X, b1.cnt_x}, 0);
        chk("rst_raddr", b1.mem_raddr, 0);
        xrst = 1'b1;

        // Load kidx=5 with one-cycle read latency
        tick();
        b1.start = 1'b1; b1.kidx = 4'd5;
        tick();
        b1.start = 1'b0; b1.kidx = 4'd0;
        chk("ld_raddr", b1.mem_raddr, RA5);
        chk("ld_busy", b1.busy, 1);
        chk("ld_ready_c1", b1.ready, 0);
        tick();
        chk("ld_ready_c2", b1.ready, 0);
        tick();
        chk("ld_ready_c3", b1.ready, 1);
        chk("ld_wq", b1.w_q, LOADW);
        chk("ld_busy_run", b1.busy, 1);

        // x shifts, then x wrap restores home
        b1.w_xin = XIN1; b1.step = 1'b1;
        tick();
        b1.step = 1'b0;
        chk("x1_cnt", b1.cnt_x, 1);
        chk("x1_wq", b1.w_q, XIN1);
        b1.w_xin = XIN2; b1.step = 1'b1;
        tick();
        chk("x2_cnt", b1.cnt_x, 2);
        chk("x2_wq", b1.w_q, XIN2);
        tick();
        b1.step = 1'b0;
        chk("xwrap_wq", b1.w_q, LOADW);
        chk("xwrap_cnt_x", b1.cnt_x, 0);
        chk("xwrap_cnt_X", b1.cnt_X, 1);

        // Advance to x=2, X=18, then the y step pulls from above
        b1.w_xin = XIN1; b1.step = 1'b1;
        for (int i = 0; i < 53; i++) tick();
        b1.step = 1'b0;
        chk("pre_y_cnt_x", b1.cnt_x, 2);
        chk("pre_y_cnt_X", b1.cnt_X, 18);
        b1.w_yin = YIN3; b1.step = 1'b1;
        tick();
        b1.step = 1'b0;
        chk("ystep_wq", b1.w_q, YIN3);
        chk("ystep_cnt_y", b1.cnt_y, 1);
        chk("ystep_cnt_X", b1.cnt_X, 0);
        chk("ystep_cnt_x", b1.cnt_x, 0);

        // Rest of the scan (57 steps done, 3192 left); a start mid-run must be ignored
        nfin = 0; fin_at = 0;
        for (int i = 1; i <= 3192; i++) begin
            b1.step  = 1'b1;
            b1.start = (i == 100);
            b1.kidx  = (i == 100) ? 4'd9 : 4'd0;
            tick();
            if (b1.finish === 1'b1) begin
                nfin++;
                fin_at = i;
            end
        end
        b1.step = 1'b0;
        chk("scan_nfin", nfin, 1);
        chk("scan_fin_at", fin_at, 3192);
        chk("scan_wq_home", b1.w_q, LOADW);
        chk("scan_ready", b1.ready, 0);
        chk("scan_busy_fin", b1.busy, 1);
        chk("scan_cnts", {b1.cnt_Y, b1.cnt_y, b1.cnt_X, b1.cnt_x}, 0);
        chk("scan_raddr", b1.mem_raddr, RA5);
        // start coincident with finish
        b1.start = 1'b1; b1.kidx = 4'd9;
        tick();
        b1.start = 1'b0; b1.kidx = 4'd0;
        chk("finstart_busy", b1.busy, 0);
        chk("finstart_finish", b1.finish, 0);
        chk("finstart_raddr", b1.mem_raddr, RA5);
        tick();
        chk("finstart_busy2", b1.busy, 0);
        chk("finstart_ready2", b1.ready, 0);

        // Steps during LOAD are dropped
        b1.start = 1'b1; b1.kidx = 4'd5;
        tick();
        b1.start = 1'b0; b1.kidx = 4'd0;
        b1.w_xin = XIN1; b1.step = 1'b1;
        tick();
        tick();
        b1.step = 1'b0;
        chk("ldstep_ready", b1.ready, 1);
        chk("ldstep_cnt_x", b1.cnt_x, 0);
        chk("ldstep_wq", b1.w_q, LOADW);

        // Move to X=7, then async reset mid-run
        b1.step = 1'b1;
        for (int i = 0; i < 21; i++) tick();
        b1.step = 1'b0;
        chk("mid_cnt_X", b1.cnt_X, 7);
        xrst = 1'b0;
        #1;
        chk("arst_wq", b1.w_q, 128'h0);
        chk("arst_cnt_X", b1.cnt_X, 0);
        chk("arst_ready", b1.ready, 0);
        chk("arst_busy", b1.busy, 0);
        chk("arst_raddr", b1.mem_raddr, 0);
        tick();
        xrst = 1'b1;

        // Reload both cells: RD_LAT=1 ready after 3 cycles, RD_LAT=3 after 5
        tick();
        b1.start = 1'b1; b1.kidx = 4'd5;
        b3.start = 1'b1; b3.kidx = 4'd5;
        tick();
        b1.start = 1'b0; b1.kidx = 4'd0;
        b3.start = 1'b0; b3.kidx = 4'd0;
        chk("rl3_raddr", b3.mem_raddr, RA5);
        tick();
        tick();
        chk("rl1_ready", b1.ready, 1);
        chk("rl1_wq", b1.w_q, LOADW);
        chk("rl3_ready_c3", b3.ready, 0);
        tick();
        chk("rl3_ready_c4", b3.ready, 0);
        tick();
        chk("rl3_ready_c5", b3.ready, 1);
        chk("rl3_wq", b3.w_q, LOADW);
        chk("rl3_busy", b3.busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
